// File: rtl/count_run_sequencer_pkg.sv
// Shared types and helpers for the count-run sequencer: FSM states, step-select codes,
// step decoding and LED bar thresholds.
package count_run_sequencer_pkg;

    localparam int unsigned ValueW = 10;
    localparam int unsigned QCntW  = 3;
    localparam int unsigned EntryW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StHold
    } state_e;

    typedef enum logic [1:0] {
        SelNone = 2'd0,
        SelOne  = 2'd1,
        SelFour = 2'd2,
        SelTen  = 2'd3
    } sel_e;

    function automatic logic [ValueW-1:0] step_of(input logic [1:0] sel);
        logic [ValueW-1:0] step;
        case (sel)
            SelOne:  step = ValueW'(1);
            SelFour: step = ValueW'(4);
            SelTen:  step = ValueW'(10);
            default: step = '0;
        endcase
        return step;
    endfunction

    // Threshold for LED bit k; only ever called with constant arguments.
    function automatic logic [ValueW-1:0] led_thresh(input int unsigned limit,
                                                     input int unsigned k);
        return ValueW'(((k + 1) * limit) / 5);
    endfunction

endpackage

// File: rtl/count_run_sequencer_fifo.sv
// Run-request queue: DEPTH entries of {manual, sel}, with push, pop and occupancy count.
module count_run_sequencer_fifo
    import count_run_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [EntryW-1:0] i_data,
    input  logic              i_pop,
    output logic [EntryW-1:0] o_data,
    output logic [QCntW-1:0]  o_count,
    output logic              o_full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [EntryW-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [QCntW-1:0]  r_count;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == QCntW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !w_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/count_run_sequencer.sv
// Runs queued +1/+4/+10 count sequences one at a time on a shared saturating counter,
// in automatic (internal tick) or manual (pulse) mode, with LED bar and status outputs.
module count_run_sequencer
    import count_run_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned HOLD_CYC = 50_000_000,
    parameter int unsigned LIMIT    = 100,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [1:0]        req_sel,
    input  logic              req_manual,
    output logic              req_ready,
    input  logic              manual_pulse,
    input  logic              cancel,
    output logic [ValueW-1:0] value,
    output logic [1:0]        active_sel,
    output logic              active_manual,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [QCntW-1:0]  q_count,
    output logic [4:0]        led
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [ValueW-1:0] LimitV = ValueW'(LIMIT);

    state_e            r_state;
    state_e            w_state_next;
    logic [ValueW-1:0] r_value;
    logic [1:0]        r_sel;
    logic              r_manual;
    logic              r_done;
    logic              r_overflow;
    logic [TickW-1:0]  r_tick;
    logic [HoldW-1:0]  r_hold;

    logic [EntryW-1:0] w_head;
    logic [QCntW-1:0]  w_q_count;
    logic              w_full;
    logic              w_legal_req;
    logic              w_push;
    logic              w_pop;
    logic              w_tick;
    logic              w_event;
    logic [ValueW:0]   w_sum;
    logic [ValueW-1:0] w_value_inc;

    assign w_legal_req = req_valid && (req_sel != SelNone);
    assign w_push      = w_legal_req && !w_full;
    assign w_pop       = (r_state == StLoad);

    count_run_sequencer_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  ({req_manual, req_sel}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_q_count),
        .o_full  (w_full)
    );

    assign w_tick      = (r_tick == TickW'(TICK_DIV - 1));
    assign w_event     = (r_state == StRun) && (r_manual ? manual_pulse : w_tick);
    assign w_sum       = {1'b0, r_value} + {1'b0, step_of(r_sel)};
    assign w_value_inc = (w_sum >= {1'b0, LimitV}) ? LimitV : w_sum[ValueW-1:0];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_q_count != '0) w_state_next = StLoad;
            StLoad:  w_state_next = StRun;
            StRun:   if (r_value == LimitV) w_state_next = StHold;
            StHold:  if (r_hold == HoldW'(HOLD_CYC - 1)) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        // Abort wins over any increment or completion in the same cycle.
        if (cancel && (r_state != StIdle)) w_state_next = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_value    <= '0;
            r_sel      <= '0;
            r_manual   <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_tick     <= '0;
            r_hold     <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == StRun) && (w_state_next == StHold);
            if (w_legal_req && w_full) r_overflow <= 1'b1;

            if ((r_state == StLoad) && !cancel) begin
                r_sel    <= w_head[1:0];
                r_manual <= w_head[2];
                r_value  <= '0;
            end else if (w_event && !cancel) begin
                r_value <= w_value_inc;
            end
            if (w_state_next == StIdle) begin
                r_sel    <= '0;
                r_manual <= 1'b0;
            end

            r_tick <= ((r_state == StRun) && !w_tick) ? r_tick + 1'b1 : '0;
            r_hold <= (r_state == StHold) ? r_hold + 1'b1 : '0;
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_led
        localparam logic [ValueW-1:0] Thresh = led_thresh(LIMIT, k);
        assign led[k] = (r_value >= Thresh);
    end

    assign value         = r_value;
    assign active_sel    = r_sel;
    assign active_manual = r_manual;
    assign busy          = (r_state != StIdle);
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign q_count       = w_q_count;
    assign req_ready     = !w_full;

endmodule

// File: tb/tb_count_run_sequencer.sv
// Directed bench: LIMIT=20 instance for run, queue, cancel and reset scenarios, plus a
// LIMIT=22 instance for saturation.
module tb_count_run_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_manual;
    logic       manual_pulse;
    logic       cancel;

    logic       req_ready;
    logic [9:0] value;
    logic [1:0] active_sel;
    logic       active_manual;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [2:0] q_count;
    logic [4:0] led;

    logic       s_req_valid;
    logic [1:0] s_req_sel;
    logic       s_req_manual;
    logic       s_manual_pulse;
    logic       s_cancel;
    logic       s_req_ready;
    logic [9:0] s_value;
    logic [1:0] s_active_sel;
    logic       s_active_manual;
    logic       s_busy;
    logic       s_done;
    logic       s_overflow;
    logic [2:0] s_q_count;
    logic [4:0] s_led;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    count_run_sequencer #(
        .TICK_DIV (4),
        .HOLD_CYC (3),
        .LIMIT    (20),
        .QDEPTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_sel       (req_sel),
        .req_manual    (req_manual),
        .req_ready     (req_ready),
        .manual_pulse  (manual_pulse),
        .cancel        (cancel),
        .value         (value),
        .active_sel    (active_sel),
        .active_manual (active_manual),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .q_count       (q_count),
        .led           (led)
    );

    count_run_sequencer #(
        .TICK_DIV (4),
        .HOLD_CYC (3),
        .LIMIT    (22),
        .QDEPTH   (4)
    ) dut22 (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (s_req_valid),
        .req_sel       (s_req_sel),
        .req_manual    (s_req_manual),
        .req_ready     (s_req_ready),
        .manual_pulse  (s_manual_pulse),
        .cancel        (s_cancel),
        .value         (s_value),
        .active_sel    (s_active_sel),
        .active_manual (s_active_manual),
        .busy          (s_busy),
        .done          (s_done),
        .overflow      (s_overflow),
        .q_count       (s_q_count),
        .led           (s_led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic man);
        req_valid  = 1'b1;
        req_sel    = sel;
        req_manual = man;
        step(1);
        req_valid  = 1'b0;
        req_sel    = 2'd0;
        req_manual = 1'b0;
    endtask

    task automatic pulse();
        manual_pulse = 1'b1;
        step(1);
        manual_pulse = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_sel        = 2'd0;
        req_manual     = 1'b0;
        manual_pulse   = 1'b0;
        cancel         = 1'b0;
        s_req_valid    = 1'b0;
        s_req_sel      = 2'd0;
        s_req_manual   = 1'b0;
        s_manual_pulse = 1'b0;
        s_cancel       = 1'b0;
        step(2);
        reset = 1'b0;

        // Reset state
        chk("rst_value", value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_qcount", q_count, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_led", led, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_active_sel", active_sel, 0);

        // Auto +4 run
        push(2'd2, 1'b0);
        chk("a4_qcount", q_count, 1);
        step(1);
        chk("a4_load_busy", busy, 1);
        step(1);
        chk("a4_run_sel", active_sel, 2);
        chk("a4_run_val0", value, 0);
        step(3);
        chk("a4_before_tick", value, 0);
        step(1);
        chk("a4_val4", value, 4);
        step(4);
        chk("a4_val8", value, 8);
        chk("a4_led8", led, 5'b00011);
        step(4);
        chk("a4_val12", value, 12);
        step(4);
        chk("a4_val16", value, 16);
        step(4);
        chk("a4_val20", value, 20);
        chk("a4_led20", led, 5'b11111);
        chk("a4_done_early", done, 0);
        step(1);
        chk("a4_done", done, 1);
        chk("a4_hold_busy", busy, 1);
        step(1);
        chk("a4_done_pulse", done, 0);
        step(1);
        chk("a4_hold_busy2", busy, 1);
        step(1);
        chk("a4_idle_busy", busy, 0);
        chk("a4_idle_value", value, 20);
        chk("a4_idle_sel", active_sel, 0);

        // Manual +10 run
        push(2'd3, 1'b1);
        step(1);
        chk("m10_load_value", value, 20);
        step(1);
        chk("m10_run_val0", value, 0);
        chk("m10_sel", active_sel, 3);
        chk("m10_manual", active_manual, 1);
        step(8);
        chk("m10_no_tick", value, 0);
        pulse();
        chk("m10_val10", value, 10);
        step(20);
        chk("m10_hold10", value, 10);
        chk("m10_led10", led, 5'b00011);
        pulse();
        chk("m10_val20", value, 20);
        chk("m10_done_early", done, 0);
        step(1);
        chk("m10_done", done, 1);
        step(3);
        chk("m10_idle", busy, 0);

        // Queue full: M0 manual +10, then R1..R5 while busy
        push(2'd3, 1'b1);
        push(2'd2, 1'b0);
        push(2'd3, 1'b1);
        push(2'd3, 1'b0);
        push(2'd1, 1'b0);
        chk("qf_count4", q_count, 4);
        chk("qf_ready0", req_ready, 0);
        chk("qf_ovf_before", overflow, 0);
        push(2'd2, 1'b0);
        chk("qf_count_drop", q_count, 4);
        chk("qf_ovf", overflow, 1);
        chk("qf_m0_sel", active_sel, 3);
        chk("qf_m0_manual", active_manual, 1);
        chk("qf_m0_noauto", value, 0);
        pulse();
        pulse();
        chk("qf_m0_20", value, 20);
        step(1);
        chk("qf_m0_done", done, 1);
        step(3);
        chk("qf_gap_idle", busy, 0);
        chk("qf_gap_q", q_count, 4);
        step(1);
        chk("qf_load_busy", busy, 1);
        step(1);
        chk("qf_r1_q", q_count, 3);
        chk("qf_r1_ready", req_ready, 1);
        chk("qf_r1_sel", active_sel, 2);
        chk("qf_r1_manual", active_manual, 0);

        // Cancel mid-run with value 8
        step(8);
        chk("cx_val8", value, 8);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        chk("cx_idle", busy, 0);
        chk("cx_nodone", done, 0);
        chk("cx_frozen", value, 8);
        chk("cx_q_kept", q_count, 3);
        step(1);
        chk("cx_load", busy, 1);
        step(1);
        chk("cx_r2_val0", value, 0);
        chk("cx_r2_sel", active_sel, 3);
        chk("cx_r2_manual", active_manual, 1);
        chk("cx_r2_q", q_count, 2);

        push(2'd1, 1'b0);
        chk("cx_push_q", q_count, 3);
        chk("cx_ovf_sticky", overflow, 1);
        pulse();
        pulse();
        chk("r2_val20", value, 20);
        step(1);
        chk("r2_done", done, 1);
        step(5);
        chk("r3_sel", active_sel, 3);
        chk("r3_manual", active_manual, 0);
        chk("r3_q", q_count, 2);
        step(4);
        chk("r3_val10", value, 10);
        step(4);
        chk("r3_val20", value, 20);
        step(1);
        chk("r3_done", done, 1);
        step(1);

        // Reset mid-HOLD with two entries queued
        chk("rh_q2", q_count, 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rh_value", value, 0);
        chk("rh_busy", busy, 0);
        chk("rh_q", q_count, 0);
        chk("rh_ready", req_ready, 1);
        chk("rh_ovf", overflow, 0);
        chk("rh_led", led, 0);
        chk("rh_done", done, 0);
        chk("rh_sel", active_sel, 0);
        chk("rh_manual", active_manual, 0);

        req_valid = 1'b1;
        req_sel   = 2'd0;
        step(1);
        req_valid = 1'b0;
        chk("ill_q", q_count, 0);
        chk("ill_ovf", overflow, 0);
        step(2);
        chk("ill_idle", busy, 0);

        // Saturation on LIMIT=22 instance
        s_req_valid = 1'b1;
        s_req_sel   = 2'd2;
        step(1);
        s_req_valid = 1'b0;
        s_req_sel   = 2'd0;
        chk("sat_q", s_q_count, 1);
        step(2);
        chk("sat_val0", s_value, 0);
        step(20);
        chk("sat_val20", s_value, 20);
        chk("sat_led20", s_led, 5'b01111);
        step(4);
        chk("sat_val22", s_value, 22);
        chk("sat_led22", s_led, 5'b11111);
        step(1);
        chk("sat_done", s_done, 1);
        step(3);
        chk("sat_idle", s_busy, 0);
        chk("sat_final", s_value, 22);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
